// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide unit: shift-add multiplier and restoring divider
// sharing one 2*XLEN accumulator, with a one-cycle path for divide corner cases.
module muldiv_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] src_a_i,
    input  logic [XLEN-1:0] src_b_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int unsigned CW = $clog2(XLEN) + 1;
    localparam int unsigned AW = 2 * XLEN;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            busy_d, done_d;

    logic [2:0]      op_q;
    logic [XLEN-1:0] opnd_q;
    logic [AW-1:0]   acc_q;
    logic [CW-1:0]   cnt_q;
    logic            quot_neg_q, rem_neg_q;

    logic            a_signed, b_signed, neg_a, neg_b;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, special, accept, last;
    logic [XLEN-1:0] special_res;

    logic [XLEN:0]   mul_sum;
    logic [AW-1:0]   mul_next;
    logic [XLEN:0]   rem_sh;
    logic            div_ge;
    logic [XLEN-1:0] rem_nx;
    logic [AW-1:0]   div_next;
    logic [AW-1:0]   acc_step;
    logic [AW-1:0]   prod_fix;
    logic [XLEN-1:0] quot, final_res;

    // Request decode: which operands are signed, magnitudes and the one-cycle corner cases
    always_comb begin
        a_signed = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                   (funct3_i == 3'b100) || (funct3_i == 3'b110);
        b_signed = (funct3_i == 3'b001) || (funct3_i == 3'b100) || (funct3_i == 3'b110);
        neg_a    = a_signed && src_a_i[XLEN-1];
        neg_b    = b_signed && src_b_i[XLEN-1];
        a_mag    = neg_a ? XLEN'(-src_a_i) : src_a_i;
        b_mag    = neg_b ? XLEN'(-src_b_i) : src_b_i;
        div_zero = funct3_i[2] && (src_b_i == '0);
        div_ovf  = ((funct3_i == 3'b100) || (funct3_i == 3'b110)) &&
                   (src_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (src_b_i == '1);
        special  = div_zero || div_ovf;
        if (div_zero) begin
            special_res = funct3_i[1] ? src_a_i : '1;
        end else begin
            special_res = funct3_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
        accept = (state_q == IDLE) && start_i && !flush_i;
        last   = (cnt_q == CW'(XLEN - 1));
    end

    // One iteration: multiplier bit from acc LSB, quotient bit into acc LSB
    always_comb begin
        mul_sum  = {1'b0, acc_q[AW-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        rem_sh   = {acc_q[AW-1:XLEN], acc_q[XLEN-1]};
        div_ge   = (rem_sh >= {1'b0, opnd_q});
        rem_nx   = div_ge ? (rem_sh[XLEN-1:0] - opnd_q) : rem_sh[XLEN-1:0];
        div_next = {rem_nx, acc_q[XLEN-2:0], div_ge};
        acc_step = op_q[2] ? div_next : mul_next;
    end

    // Final sign fix applied to the values produced by the last iteration
    always_comb begin
        prod_fix = quot_neg_q ? AW'(-mul_next) : mul_next;
        quot     = div_next[XLEN-1:0];
        case (op_q)
            3'b000:                 final_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod_fix[AW-1:XLEN];
            3'b100, 3'b101:         final_res = quot_neg_q ? XLEN'(-quot) : quot;
            default:                final_res = rem_neg_q ? XLEN'(-rem_nx) : rem_nx;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_o  <= busy_d;
            done_o  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = special ? DONE : CALC;
                end
            end
            CALC: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (last) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status flags are registered copies of the state being entered
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        if (state_d != IDLE) begin
            busy_d = 1'b1;
        end
        if (state_d == DONE) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q       <= '0;
            opnd_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            result_o   <= '0;
        end else if (accept) begin
            if (special) begin
                result_o <= special_res;
            end else begin
                op_q       <= funct3_i;
                opnd_q     <= funct3_i[2] ? b_mag : a_mag;
                acc_q      <= funct3_i[2] ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
                cnt_q      <= '0;
                quot_neg_q <= neg_a ^ neg_b;
                rem_neg_q  <= neg_a;
            end
        end else if ((state_q == CALC) && !flush_i) begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + CW'(1);
            if (last) begin
                result_o <= final_res;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: driver pushes model results, a monitor pops on done_o.
module tb_muldiv_sequencer;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            flush = 1'b0;
    logic [2:0]      funct3 = '0;
    logic [XLEN-1:0] src_a = '0;
    logic [XLEN-1:0] src_b = '0;
    logic            busy, done;
    logic [XLEN-1:0] result;

    muldiv_sequencer #(.XLEN(XLEN)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .funct3_i(funct3),
        .src_a_i(src_a), .src_b_i(src_b), .flush_i(flush),
        .busy_o(busy), .done_o(done), .result_o(result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] res;
        int          acc_cyc;
        int          lat;
    } exp_t;

    exp_t        sbq[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] last_exp = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // RISC-V M-extension semantics computed with plain 64-bit arithmetic
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        int          ia, ib;
        logic [31:0] r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = a;
        ib = b;
        p  = '0;
        case (f)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF :
                      (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(ia / ib);
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a :
                      (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(ia % ib);
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic bit one_cycle(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2]) return 1'b0;
        if (b == 0) return 1'b1;
        return (f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit expect_done);
        exp_t e;
        int   n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            check("idle_timeout", 32'(busy), 32'd0);
        end
        funct3 = f;
        src_a  = a;
        src_b  = b;
        start  = 1'b1;
        if (expect_done) begin
            e.res     = model(f, a, b);
            e.acc_cyc = cyc + 1;
            e.lat     = one_cycle(f, a, b) ? 0 : XLEN;
            sbq.push_back(e);
            last_exp = e.res;
        end
        @(negedge clk);
        start = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && done) begin
                if (sbq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done: got done_o=1 result %h expected no done (t=%0t)", result, $time);
                end else begin
                    e = sbq.pop_front();
                    check("result", result, e.res);
                    check("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
                    check("busy_with_done", 32'(busy), 32'd1);
                end
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            check("drain_timeout", 32'(sbq.size()), 32'd0);
            sbq.delete();
        end
        @(negedge clk);
        check("idle_after_done", {30'd0, busy, done}, 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 20));
            5: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed corner vectors
        issue(3'd0, 32'h7, 32'hFFFF_FFFD, 1'b1);
        issue(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b1);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        issue(3'd4, -32'd7, 32'd2, 1'b1);
        issue(3'd6, -32'd7, 32'd2, 1'b1);
        issue(3'd5, 32'hFFFF_FFFF, 32'h10, 1'b1);
        issue(3'd7, 32'hFFFF_FFFF, 32'h10, 1'b1);
        issue(3'd5, 32'h1234_5678, 32'd0, 1'b1);
        issue(3'd6, 32'd5, 32'd0, 1'b1);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        drain();

        // Random operations, issued back to back
        for (int i = 0; i < 50; i++) begin
            issue(3'($urandom_range(0, 7)), pick(), pick(), 1'b1);
        end
        drain();

        // Flush on the tenth iteration of a DIV: no done, result untouched
        issue(3'd4, 32'd1000, 32'd7, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_result", result, last_exp);
        repeat (40) @(negedge clk);
        check("flush_result_later", result, last_exp);

        // start together with flush in IDLE is dropped
        funct3 = 3'd0;
        src_a  = 32'd3;
        src_b  = 32'd4;
        start  = 1'b1;
        flush  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("start_flush_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("start_flush_idle", {30'd0, busy, done}, 32'd0);

        // start pulsed while busy is ignored
        issue(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
        repeat (5) @(negedge clk);
        funct3 = 3'd5;
        src_a  = 32'd9;
        src_b  = 32'd0;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (3) @(negedge clk);
        check("no_queued_start", 32'(busy), 32'd0);

        // Asynchronous reset mid-CALC clears outputs without a clock edge
        issue(3'd1, 32'h1357_9BDF, 32'h2468_ACE0, 1'b0);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_exp = '0;
        repeat (40) @(negedge clk);
        check("post_rst_result", result, 32'd0);

        issue(3'd0, 32'd12345, 32'd678, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
